pack_line_controller: RTL and testbench
=======================================

Name: pack_line_controller

Overview:
- Sequencing FSM for the compressed-bit packing datapath. Accepts one variable-length compressed word per handshake and produces the controls that place its bits into the 128-bit output line register.
- Tracks line fill and splits words that straddle a line boundary.
- Emits full or padded lines to the downstream writer with valid/ready backpressure.
- Sits between the per-word compressor stage and the line packer/shift array.

Parameters:
- CACHE_LINE, 128, output line width in bits
- WORD_SIZE, 64, maximum compressed word length in bits
- LEN_W, 7, width of length input; must hold WORD_SIZE
- FILL_W, 8, width of fill/shift counters; must hold CACHE_LINE

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous active-low reset
- i_len_valid  input  1  compressed word length valid
- i_len  input  LEN_W  compressed length, 0..WORD_SIZE
- i_last  input  1  qualifies the final word of a block
- o_len_ready  output  1  controller accepts i_len this cycle
- o_shift_amount  output  FILL_W  destination bit offset in the line
- o_src_offset  output  LEN_W  first source bit of the word to write
- o_wr_en  output  1  packer writes o_wr_bits bits this cycle
- o_wr_bits  output  FILL_W  number of bits written (1..WORD_SIZE, or pad count)
- o_pad_en  output  1  write is zero padding rather than word data
- o_line_valid  output  1  line register holds a line for downstream
- i_line_ready  input  1  downstream accepts the line
- o_line_last  output  1  emitted line is the final line of a block
- o_len_err  output  1  one-cycle pulse: i_len > WORD_SIZE was accepted

Behaviour:
- Reset (async, i_reset=0): state=ACCUM; fill=0; spill=0; last_pend=0. All outputs are 0 except o_len_ready, which is 1 in ACCUM.
- States: ACCUM, EMIT, SPILL, FLUSH.
- ACCUM:
  - o_len_ready=1. A word is accepted when i_len_valid=1; L=i_len, with L>WORD_SIZE clamped to WORD_SIZE and o_len_err pulsed.
  - L=0: no write; fill unchanged.
  - fill+L<CACHE_LINE: o_wr_en=1, o_shift_amount=fill, o_src_offset=0, o_wr_bits=L. Next fill=fill+L. Stay in ACCUM unless i_last (then see below).
  - fill+L==CACHE_LINE: write as above; fill<=0; go to EMIT.
  - fill+L>CACHE_LINE: write CACHE_LINE-fill bits at offset fill. spill<=fill+L-CACHE_LINE; split_src<=CACHE_LINE-fill; go to EMIT.
  - i_last accepted: last_pend<=1.
    - Straddle: EMIT first.
    - Resulting fill>0 and no straddle: go to FLUSH.
    - Resulting fill==0: go to EMIT only if a write just completed the line; otherwise (empty block/line) emit nothing and clear last_pend.
- FLUSH:
  - One cycle: o_wr_en=1, o_pad_en=1, o_shift_amount=fill, o_wr_bits=CACHE_LINE-fill.
  - Go to EMIT.
- EMIT:
  - o_line_valid=1. o_line_last=last_pend && spill==0. o_len_ready=0.
  - Hold all controls stable until i_line_ready.
  - On handshake: if spill>0, go to SPILL; else fill<=0, clear last_pend, go to ACCUM.
- SPILL:
  - One cycle: o_wr_en=1, o_shift_amount=0, o_src_offset=split_src, o_wr_bits=spill.
  - fill<=spill; spill<=0.
  - Then go to FLUSH if last_pend, else ACCUM.
- Latency:
  - Accepted word writes in the same cycle; no bubble for non-straddling words.
  - Straddle costs EMIT (≥1 cycle) plus 1 SPILL cycle.
- Backpressure: EMIT may last indefinitely. No word is accepted outside ACCUM.
- Reset mid-operation discards any partial line and pending spill.
- All arithmetic is FILL_W unsigned. fill never exceeds CACHE_LINE-1 outside EMIT.

Optional Feature:
- Macro PACK_LINE_STATS_EN.
- Defined: adds outputs o_line_count[31:0] (lines emitted), o_bit_count[31:0] (data bits written, pad excluded) and o_pad_count[31:0]. All are cleared by reset and saturate at max.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pack_ctrl_pkg: state enum (ACCUM, EMIT, SPILL, FLUSH); CACHE_LINE/WORD_SIZE defaults; a fill_t typedef of width FILL_W.
- One natural sub-module: pack_line_stats, holding the saturating counters and instantiated only under PACK_LINE_STATS_EN.

Test Plan:
- Two L=64 words back to back:
  - Both accepted with no bubble, at shift 0 then 64.
  - EMIT with o_line_valid=1 and o_line_last=0.
  - i_line_ready=1 returns to ACCUM with fill=0.
- Fill=100, then L=40 (straddle):
  - Write 28 bits at shift 100, src 0.
  - EMIT; hold i_line_ready=0 for 5 cycles and check outputs stay stable.
  - SPILL writes 12 bits at shift 0, src 28; fill=12.
- L=30 with i_last=1 from empty:
  - Write 30 at shift 0.
  - FLUSH pads 98 bits at shift 30.
  - EMIT with o_line_last=1.
- Fill=120, then L=20 with i_last:
  - Write 8 bits.
  - EMIT with o_line_last=0.
  - SPILL writes 12 bits, src 8.
  - FLUSH pads 116.
  - EMIT with o_line_last=1.
- L=0 and L=70 cases:
  - L=0: accepted with no write.
  - L=70: clamped to 64 and o_len_err pulses for one cycle.
- Assert i_reset=0 during EMIT with spill>0:
  - All outputs clear asynchronously.
  - After release: ACCUM, fill=0, o_len_ready=1.

Source files
------------

// File: rtl/pack_ctrl_pkg.sv
// Shared types and default sizes for the pack line controller.
package pack_ctrl_pkg;

  localparam int CACHE_LINE_DEF = 128;
  localparam int WORD_SIZE_DEF  = 64;
  localparam int LEN_W_DEF      = 7;
  localparam int FILL_W_DEF     = 8;

  typedef logic [FILL_W_DEF-1:0] fill_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    SPILL = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/pack_line_stats.sv
// Saturating activity counters for the pack line controller.
// Only instantiated when PACK_LINE_STATS_EN is defined.
module pack_line_stats
  import pack_ctrl_pkg::*;
#(
  parameter int FILL_W = FILL_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_line_done,
  input  logic              i_data_en,
  input  logic [FILL_W-1:0] i_data_bits,
  input  logic              i_pad_en,
  input  logic [FILL_W-1:0] i_pad_bits,
  output logic [31:0]       o_line_count,
  output logic [31:0]       o_bit_count,
  output logic [31:0]       o_pad_count
);

  logic [32:0] line_sum;
  logic [32:0] bit_sum;
  logic [32:0] pad_sum;

  // Widened sums; bit 32 set means the counter would wrap.
  always_comb begin
    line_sum = {1'b0, o_line_count} + 33'd1;
    bit_sum  = {1'b0, o_bit_count} + 33'(i_data_bits);
    pad_sum  = {1'b0, o_pad_count} + 33'(i_pad_bits);
  end

  // Counter registers, pinned at all-ones once they saturate.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_line_count <= '0;
      o_bit_count  <= '0;
      o_pad_count  <= '0;
    end else begin
      if (i_line_done)
        o_line_count <= line_sum[32] ? '1 : line_sum[31:0];
      if (i_data_en)
        o_bit_count <= bit_sum[32] ? '1 : bit_sum[31:0];
      if (i_pad_en)
        o_pad_count <= pad_sum[32] ? '1 : pad_sum[31:0];
    end
  end

endmodule

// File: rtl/pack_line_controller.sv
// Sequencing FSM for the compressed-bit packing datapath: places variable
// length words into a line register, splits words that straddle a line,
// pads the final line of a block and hands lines downstream.
// Optional macro PACK_LINE_STATS_EN adds line/bit/pad counters.
//
// state | meaning
// ACCUM | accept words, write them at the current fill offset
// EMIT  | line complete, wait for downstream handshake
// SPILL | write the tail of a straddling word at offset 0
// FLUSH | pad the rest of the final line with zeros
module pack_line_controller
  import pack_ctrl_pkg::*;
#(
  parameter int CACHE_LINE = CACHE_LINE_DEF,
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FILL_W     = FILL_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_len_valid,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_last,
  output logic              o_len_ready,
  output logic [FILL_W-1:0] o_shift_amount,
  output logic [LEN_W-1:0]  o_src_offset,
  output logic              o_wr_en,
  output logic [FILL_W-1:0] o_wr_bits,
  output logic              o_pad_en,
  output logic              o_line_valid,
  input  logic              i_line_ready,
  output logic              o_line_last,
  output logic              o_len_err
`ifdef PACK_LINE_STATS_EN
  ,
  output logic [31:0]       o_line_count,
  output logic [31:0]       o_bit_count,
  output logic [31:0]       o_pad_count
`endif
);

  localparam logic [FILL_W-1:0] CL_F = FILL_W'(CACHE_LINE);
  localparam logic [LEN_W-1:0]  WS_L = LEN_W'(WORD_SIZE);

  state_t            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] spill_q, spill_d;
  logic [LEN_W-1:0]  split_q, split_d;
  logic              last_q, last_d;

  logic              len_over;
  logic [LEN_W-1:0]  len_c;
  logic [FILL_W-1:0] len_f;
  logic [FILL_W-1:0] sum;
  logic [FILL_W-1:0] room;

  // Clamp the incoming length and precompute fill arithmetic.
  always_comb begin
    len_over = (i_len > WS_L);
    len_c    = len_over ? WS_L : i_len;
    len_f    = FILL_W'(len_c);
    sum      = fill_q + len_f;
    room     = CL_F - fill_q;
  end

  // State and bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ACCUM;
      fill_q  <= '0;
      spill_q <= '0;
      split_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      spill_q <= spill_d;
      split_q <= split_d;
      last_q  <= last_d;
    end
  end

  // Next-state and packer control outputs.
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    spill_d        = spill_q;
    split_d        = split_q;
    last_d         = last_q;
    o_len_ready    = 1'b0;
    o_shift_amount = '0;
    o_src_offset   = '0;
    o_wr_en        = 1'b0;
    o_wr_bits      = '0;
    o_pad_en       = 1'b0;
    o_line_valid   = 1'b0;
    o_line_last    = 1'b0;
    o_len_err      = 1'b0;

    case (state_q)
      ACCUM: begin
        o_len_ready = 1'b1;
        if (i_len_valid) begin
          o_len_err = len_over;
          if (len_f != '0) begin
            o_wr_en        = 1'b1;
            o_shift_amount = fill_q;
            if (sum < CL_F) begin
              o_wr_bits = len_f;
              fill_d    = sum;
              if (i_last) begin
                last_d  = 1'b1;
                state_d = FLUSH;
              end
            end else if (sum == CL_F) begin
              o_wr_bits = len_f;
              fill_d    = '0;
              last_d    = i_last;
              state_d   = EMIT;
            end else begin
              // Straddle: the head fills this line, the tail waits in SPILL.
              o_wr_bits = room;
              spill_d   = sum - CL_F;
              split_d   = LEN_W'(room);
              fill_d    = '0;
              last_d    = i_last;
              state_d   = EMIT;
            end
          end else if (i_last && fill_q != '0) begin
            last_d  = 1'b1;
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        o_wr_en        = 1'b1;
        o_pad_en       = 1'b1;
        o_shift_amount = fill_q;
        o_wr_bits      = CL_F - fill_q;
        state_d        = EMIT;
      end

      EMIT: begin
        o_line_valid = 1'b1;
        o_line_last  = last_q && (spill_q == '0);
        if (i_line_ready) begin
          if (spill_q != '0) begin
            state_d = SPILL;
          end else begin
            fill_d  = '0;
            last_d  = 1'b0;
            state_d = ACCUM;
          end
        end
      end

      SPILL: begin
        o_wr_en        = 1'b1;
        o_shift_amount = '0;
        o_src_offset   = split_q;
        o_wr_bits      = spill_q;
        fill_d         = spill_q;
        spill_d        = '0;
        state_d        = last_q ? FLUSH : ACCUM;
      end

      default: state_d = ACCUM;
    endcase
  end

`ifdef PACK_LINE_STATS_EN
  pack_line_stats #(
    .FILL_W (FILL_W)
  ) u_stats (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_line_done  (o_line_valid && i_line_ready),
    .i_data_en    (o_wr_en && !o_pad_en),
    .i_data_bits  (o_wr_bits),
    .i_pad_en     (o_wr_en && o_pad_en),
    .i_pad_bits   (o_wr_bits),
    .o_line_count (o_line_count),
    .o_bit_count  (o_bit_count),
    .o_pad_count  (o_pad_count)
  );
`endif

endmodule

// File: tb/tb_pack_line_controller.sv
// Scoreboard bench for pack_line_controller (default build).
module tb_pack_line_controller;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_len_valid = 1'b0;
  logic [6:0] i_len = '0;
  logic       i_last = 1'b0;
  logic       o_len_ready;
  logic [7:0] o_shift_amount;
  logic [6:0] o_src_offset;
  logic       o_wr_en;
  logic [7:0] o_wr_bits;
  logic       o_pad_en;
  logic       o_line_valid;
  logic       i_line_ready = 1'b0;
  logic       o_line_last;
  logic       o_len_err;

  typedef struct {
    logic [7:0] shift;
    logic [6:0] src;
    logic [7:0] bits;
    logic       pad;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic obs_err;
  logic obs_wr;

  pack_line_controller dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_len_valid    (i_len_valid),
    .i_len          (i_len),
    .i_last         (i_last),
    .o_len_ready    (o_len_ready),
    .o_shift_amount (o_shift_amount),
    .o_src_offset   (o_src_offset),
    .o_wr_en        (o_wr_en),
    .o_wr_bits      (o_wr_bits),
    .o_pad_en       (o_pad_en),
    .o_line_valid   (o_line_valid),
    .i_line_ready   (i_line_ready),
    .o_line_last    (o_line_last),
    .o_len_err      (o_len_err)
  );

  always #5 i_clk = ~i_clk;

  // Every packer write is popped from the scoreboard and compared.
  always @(negedge i_clk) begin : monitor
    wr_t e;
    if (i_reset && o_wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got shift=%0d src=%0d bits=%0d pad=%b, required no write",
                 o_shift_amount, o_src_offset, o_wr_bits, o_pad_en);
      end else begin
        e = exp_q.pop_front();
        if (o_shift_amount !== e.shift || o_src_offset !== e.src ||
            o_wr_bits !== e.bits || o_pad_en !== e.pad) begin
          bad++;
          $display("FAIL wr_fields: got shift=%0d src=%0d bits=%0d pad=%b, required shift=%0d src=%0d bits=%0d pad=%b",
                   o_shift_amount, o_src_offset, o_wr_bits, o_pad_en,
                   e.shift, e.src, e.bits, e.pad);
        end
      end
    end
  end

  task automatic push_wr(input int sh, input int src, input int bits, input bit pad);
    wr_t e;
    e.shift = 8'(sh);
    e.src   = 7'(src);
    e.bits  = 8'(bits);
    e.pad   = pad;
    exp_q.push_back(e);
  endtask

  // Present one word for one cycle; accept must be immediate.
  task automatic drive_word(input int len, input bit last);
    i_len_valid = 1'b1;
    i_len       = 7'(len);
    i_last      = last;
    @(negedge i_clk);
    total++;
    if (o_len_ready !== 1'b1) begin
      bad++;
      $display("FAIL len_ready_accept: got %b required 1 (len=%0d)", o_len_ready, len);
    end
    obs_err = o_len_err;
    obs_wr  = o_wr_en;
    @(posedge i_clk);
    #1;
    i_len_valid = 1'b0;
    i_last      = 1'b0;
    i_len       = '0;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    #12;
    total++;
    if (o_len_ready !== 1'b1 || o_wr_en !== 1'b0 || o_line_valid !== 1'b0 ||
        o_line_last !== 1'b0 || o_pad_en !== 1'b0 || o_len_err !== 1'b0 ||
        o_wr_bits !== 8'd0 || o_shift_amount !== 8'd0 || o_src_offset !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b lv=%b ll=%b pad=%b err=%b bits=%0d sh=%0d src=%0d, required rdy=1 others 0",
               o_len_ready, o_wr_en, o_line_valid, o_line_last, o_pad_en, o_len_err,
               o_wr_bits, o_shift_amount, o_src_offset);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_back_to_back;
    push_wr(0, 0, 64, 0);
    push_wr(64, 0, 64, 0);
    drive_word(64, 0);
    drive_word(64, 0);
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1 || o_line_last !== 1'b0 || o_len_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_emit: got lv=%b ll=%b rdy=%b required lv=1 ll=0 rdy=0",
               o_line_valid, o_line_last, o_len_ready);
    end
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_len_ready !== 1'b1 || o_line_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_return: got rdy=%b lv=%b required rdy=1 lv=0", o_len_ready, o_line_valid);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_straddle;
    push_wr(0, 0, 64, 0);
    push_wr(64, 0, 36, 0);
    push_wr(100, 0, 28, 0);
    drive_word(64, 0);
    drive_word(36, 0);
    drive_word(40, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      total++;
      if (o_line_valid !== 1'b1 || o_line_last !== 1'b0 || o_wr_en !== 1'b0 ||
          o_len_ready !== 1'b0) begin
        bad++;
        $display("FAIL straddle_hold c=%0d: got lv=%b ll=%b wr=%b rdy=%b required lv=1 ll=0 wr=0 rdy=0",
                 c, o_line_valid, o_line_last, o_wr_en, o_len_ready);
      end
      @(posedge i_clk);
      #1;
    end
    push_wr(0, 28, 12, 0);
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_len_ready !== 1'b0 || o_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL spill_cycle: got rdy=%b wr=%b required rdy=0 wr=1", o_len_ready, o_wr_en);
    end
    @(posedge i_clk);
    #1;
    // fill must now be 12: next word lands at 12, then an empty last word pads
    push_wr(12, 0, 10, 0);
    push_wr(22, 0, 106, 1);
    drive_word(10, 0);
    drive_word(0, 1);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1 || o_line_last !== 1'b1) begin
      bad++;
      $display("FAIL zero_last_emit: got lv=%b ll=%b required lv=1 ll=1", o_line_valid, o_line_last);
    end
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
  endtask

  task automatic test_last_flush;
    push_wr(0, 0, 30, 0);
    push_wr(30, 0, 98, 1);
    drive_word(30, 1);
    @(negedge i_clk);
    total++;
    if (o_pad_en !== 1'b1 || o_len_ready !== 1'b0 || o_line_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle: got pad=%b rdy=%b lv=%b required pad=1 rdy=0 lv=0",
               o_pad_en, o_len_ready, o_line_valid);
    end
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1 || o_line_last !== 1'b1) begin
      bad++;
      $display("FAIL flush_emit: got lv=%b ll=%b required lv=1 ll=1", o_line_valid, o_line_last);
    end
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
  endtask

  task automatic test_straddle_last;
    push_wr(0, 0, 64, 0);
    push_wr(64, 0, 56, 0);
    push_wr(120, 0, 8, 0);
    drive_word(64, 0);
    drive_word(56, 0);
    drive_word(20, 1);
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1 || o_line_last !== 1'b0) begin
      bad++;
      $display("FAIL sl_first_emit: got lv=%b ll=%b required lv=1 ll=0", o_line_valid, o_line_last);
    end
    push_wr(0, 8, 12, 0);
    push_wr(12, 0, 116, 1);
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1 || o_line_last !== 1'b1) begin
      bad++;
      $display("FAIL sl_final_emit: got lv=%b ll=%b required lv=1 ll=1", o_line_valid, o_line_last);
    end
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
  endtask

  task automatic test_len_edges;
    drive_word(0, 0);
    total++;
    if (obs_wr !== 1'b0 || obs_err !== 1'b0) begin
      bad++;
      $display("FAIL len0: got wr=%b err=%b required wr=0 err=0", obs_wr, obs_err);
    end
    push_wr(0, 0, 64, 0);
    drive_word(70, 0);
    total++;
    if (obs_err !== 1'b1) begin
      bad++;
      $display("FAIL len70_err: got %b required 1", obs_err);
    end
    push_wr(64, 0, 64, 0);
    drive_word(64, 0);
    total++;
    if (obs_err !== 1'b0) begin
      bad++;
      $display("FAIL len64_err: got %b required 0", obs_err);
    end
    @(negedge i_clk);
    total++;
    if (o_len_err !== 1'b0 || o_line_valid !== 1'b1) begin
      bad++;
      $display("FAIL len_emit: got err=%b lv=%b required err=0 lv=1", o_len_err, o_line_valid);
    end
    i_line_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_line_ready = 1'b0;
    // empty block: a zero-length last word from empty emits nothing
    drive_word(0, 1);
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b0 || o_len_ready !== 1'b1 || o_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL empty_block: got lv=%b rdy=%b wr=%b required lv=0 rdy=1 wr=0",
               o_line_valid, o_len_ready, o_wr_en);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset_mid;
    push_wr(0, 0, 64, 0);
    push_wr(64, 0, 36, 0);
    push_wr(100, 0, 28, 0);
    drive_word(64, 0);
    drive_word(36, 0);
    drive_word(40, 0);
    @(negedge i_clk);
    total++;
    if (o_line_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_emit: got lv=%b required 1", o_line_valid);
    end
    #2;
    i_reset = 1'b0;
    #1;
    total++;
    if (o_line_valid !== 1'b0 || o_wr_en !== 1'b0 || o_line_last !== 1'b0 ||
        o_len_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_async_clear: got lv=%b wr=%b ll=%b rdy=%b required lv=0 wr=0 ll=0 rdy=1",
               o_line_valid, o_wr_en, o_line_last, o_len_ready);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    total++;
    if (o_len_ready !== 1'b1 || o_wr_en !== 1'b0 || o_line_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_after_release: got rdy=%b wr=%b lv=%b required rdy=1 wr=0 lv=0",
               o_len_ready, o_wr_en, o_line_valid);
    end
    @(posedge i_clk);
    #1;
    push_wr(0, 0, 10, 0);
    drive_word(10, 0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_straddle();
    test_last_flush();
    test_straddle_last();
    test_len_edges();
    test_reset_mid();
    repeat (2) @(posedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL writes_missing: got %0d outstanding required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
